// File: rtl/psum_loopback_if.sv
// rtl/psum_loopback_if.sv - issue/row and final-result stream signals of psum_loopback
interface psum_loopback_if;
  logic        in_valid;
  logic        issue_ready;
  logic [15:0] psum_to_row;
  logic [15:0] row_out;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;

  modport master (
    output in_valid,
    input  issue_ready,
    input  psum_to_row,
    output row_out,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    output issue_ready,
    output psum_to_row,
    input  row_out,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/psum_loopback.sv
// rtl/psum_loopback.sv - partial-sum loopback FIFO feeding a PE row across num_pass passes
module psum_loopback #(
  parameter int DEPTH   = 8,
  parameter int ROW_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             num_pass,
  input  logic [$clog2(DEPTH):0] num_vec,
  output logic                   busy,
  output logic                   done,
  psum_loopback_if.slave         bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = AW + 1;
  localparam logic [VW-1:0] DEPTH_V = VW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [3:0]         num_pass_q;
  logic [VW-1:0]      num_vec_q;
  logic [3:0]         pass_cnt;
  logic [VW-1:0]      vec_cnt;
  logic [15:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [VW-1:0]      count;
  logic [ROW_LAT-1:0] inflight;

  logic        fifo_empty;
  logic        start_ok;
  logic        last_vec;
  logic        last_pass;
  logic        issue;
  logic        out_hs;
  logic        push;
  logic        pop;
  logic        issue_ready_c;
  logic [15:0] psum_c;
  logic        out_valid_c;
  logic [15:0] out_data_c;
  logic        done_c;

  assign fifo_empty = (count == '0);
  assign start_ok   = start && (num_pass != 4'd0) && (num_vec != '0) && (num_vec <= DEPTH_V);
  assign last_vec   = (vec_cnt == num_vec_q - 1'b1);
  assign last_pass  = (pass_cnt == num_pass_q - 4'd1);
  assign issue      = (state_q == RUN) && bus.in_valid && issue_ready_c;
  assign out_hs     = out_valid_c && bus.out_ready;
  // The delayed valid bit lands row_out in the FIFO regardless of state.
  assign push       = inflight[ROW_LAT-1];
  assign pop        = (issue && (pass_cnt != 4'd0)) || out_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    issue_ready_c = 1'b0;
    psum_c        = 16'h0000;
    out_valid_c   = 1'b0;
    out_data_c    = 16'h0000;
    done_c        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        issue_ready_c = (pass_cnt == 4'd0) || !fifo_empty;
        if (pass_cnt != 4'd0) begin
          psum_c = mem[rd_ptr];
        end
        if (bus.in_valid && issue_ready_c && last_vec && last_pass) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid_c = !fifo_empty;
        if (out_valid_c) begin
          out_data_c = mem[rd_ptr];
        end
        // Finish only on the handshake that empties the FIFO with nothing left in the row.
        if (out_valid_c && bus.out_ready && (count == VW'(1)) && (inflight == '0)) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.issue_ready = issue_ready_c;
  assign bus.psum_to_row = psum_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_data    = out_data_c;
  assign busy            = (state_q != IDLE);
  assign done            = done_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_pass_q <= 4'd0;
      num_vec_q  <= '0;
      pass_cnt   <= 4'd0;
      vec_cnt    <= '0;
    end else if ((state_q == IDLE) && start_ok) begin
      num_pass_q <= num_pass;
      num_vec_q  <= num_vec;
      pass_cnt   <= 4'd0;
      vec_cnt    <= '0;
    end else if (issue) begin
      if (last_vec) begin
        vec_cnt  <= '0;
        pass_cnt <= pass_cnt + 4'd1;
      end else begin
        vec_cnt  <= vec_cnt + 1'b1;
      end
    end
  end

  generate
    if (ROW_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          inflight <= '0;
        end else begin
          inflight <= issue;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          inflight <= '0;
        end else begin
          inflight <= {inflight[ROW_LAT-2:0], issue};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.row_out;
    end
  end
endmodule

// File: tb/tb_psum_loopback.sv
// tb/tb_psum_loopback.sv - scoreboard bench for psum_loopback with a behavioural PE row
module tb_psum_loopback;
  localparam int DEPTH   = 8;
  localparam int ROW_LAT = 4;
  localparam int VW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    num_pass = 4'd0;
  logic [VW-1:0] num_vec = '0;
  logic          busy;
  logic          done;

  psum_loopback_if bus();

  psum_loopback #(.DEPTH(DEPTH), .ROW_LAT(ROW_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_pass (num_pass),
    .num_vec  (num_vec),
    .busy     (busy),
    .done     (done),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [15:0] pipe [ROW_LAT];
  logic [15:0] add_k [DEPTH];
  int          iss_cnt = 0;
  int          vec_idx = 0;
  int          cur_nv = 1;
  logic [15:0] psum_log[$];
  int          iss_cyc[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        vld_tr[$];
  logic        rdy_tr[$];
  logic        done_tr[$];
  logic [15:0] dat_tr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // PE row: returns psum + add_k[vector index], ROW_LAT edges after the issue edge.
  always @(negedge clk) begin
    bus.row_out = pipe[ROW_LAT-1];
    for (int i = ROW_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = 16'h0000;
    if (bus.in_valid && bus.issue_ready) begin
      pipe[0] = bus.psum_to_row + add_k[vec_idx];
      psum_log.push_back(bus.psum_to_row);
      iss_cyc.push_back(cyc);
      iss_cnt++;
      vec_idx = (vec_idx + 1 == cur_nv) ? 0 : vec_idx + 1;
    end
  end

  task automatic start_job(input logic [3:0] p, input logic [VW-1:0] v);
    @(posedge clk); #1;
    num_pass = p;
    num_vec  = v;
    start    = 1'b1;
    cur_nv   = (v == '0) ? 1 : int'(v);
    vec_idx  = 0;
    psum_log.delete();
    iss_cyc.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, output bit to);
    int tgt;
    int k;
    tgt = iss_cnt + n;
    k = 0;
    bus.in_valid = 1'b1;
    while (iss_cnt < tgt && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    bus.in_valid = 1'b0;
    to = (iss_cnt < tgt);
  endtask

  task automatic drain(input int mode, input int limit, output bit to);
    int k;
    k = 0;
    to = 1'b0;
    got_q.delete(); vld_tr.delete(); rdy_tr.delete(); done_tr.delete(); dat_tr.delete();
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (mode == 0) || (k % 3 == 0);
      @(negedge clk);
      vld_tr.push_back(bus.out_valid);
      rdy_tr.push_back(bus.out_ready);
      done_tr.push_back(done);
      dat_tr.push_back(bus.out_data);
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      k++;
      if (done) break;
      if (k >= limit) begin
        to = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({busy, done, bus.issue_ready, bus.out_valid} !== 4'b0000 || bus.psum_to_row !== 16'h0 || bus.out_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b ir=%b ov=%b psum=%h od=%h, want all 0", busy, done, bus.issue_ready, bus.out_valid, bus.psum_to_row, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_single_pass();
    bit to;
    int n;
    logic [15:0] e, g;
    add_k[0] = 16'd1; add_k[1] = 16'd2; add_k[2] = 16'd3;
    start_job(4'd1, 4'd3);
    tests_run++;
    if (busy !== 1'b1 || bus.issue_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_start: busy=%b issue_ready=%b want 1,1", busy, bus.issue_ready);
    end
    for (int i = 1; i <= 3; i++) exp_q.push_back(16'(i));
    feed(3, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL single_feed_timeout: issued fewer than 3"); end
    for (int i = 0; i < psum_log.size(); i++) begin
      tests_run++;
      if (psum_log[i] !== 16'h0000) begin
        tests_failed++;
        $display("FAIL single_psum[%0d]: got %h want 0000", i, psum_log[i]);
      end
    end
    drain(0, 100, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL single_drain_timeout: no done"); end
    n = exp_q.size();
    tests_run++;
    if (got_q.size() != n) begin tests_failed++; $display("FAIL single_count: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL single_out: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    n = 0;
    foreach (done_tr[i]) if (done_tr[i]) n++;
    tests_run++;
    if (n != 1) begin tests_failed++; $display("FAIL single_done_pulses: got %0d want 1", n); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_multi_pass();
    bit to;
    int n;
    logic [15:0] e, g;
    for (int i = 0; i < DEPTH; i++) add_k[i] = 16'd1;
    start_job(4'd3, 4'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'd3);
    feed(24, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL multi_feed_timeout: issued %0d want 24", psum_log.size()); end
    tests_run++;
    if (iss_cyc.size() == 24 && (iss_cyc[23] - iss_cyc[0]) != 23) begin
      tests_failed++;
      $display("FAIL multi_no_bubble: span %0d cycles want 23", iss_cyc[23] - iss_cyc[0]);
    end
    for (int i = 8; i < 16 && i < psum_log.size(); i++) begin
      tests_run++;
      if (psum_log[i] !== 16'd1) begin tests_failed++; $display("FAIL multi_pass2_psum[%0d]: got %0d want 1", i, psum_log[i]); end
    end
    drain(0, 100, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL multi_drain_timeout: no done"); end
    n = exp_q.size();
    tests_run++;
    if (got_q.size() != n) begin tests_failed++; $display("FAIL multi_count: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL multi_out: got %0d want %0d", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    bit to;
    int n;
    logic [15:0] e, g;
    add_k[0] = 16'd5; add_k[1] = 16'd7;
    start_job(4'd2, 4'd2);
    exp_q.push_back(16'd10); exp_q.push_back(16'd14);
    feed(4, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL stall_feed_timeout: issued %0d want 4", psum_log.size()); end
    tests_run++;
    if (iss_cyc.size() == 4 && (iss_cyc[2] - iss_cyc[1] - 1) != 3) begin
      tests_failed++;
      $display("FAIL stall_gap: got %0d idle cycles want 3", iss_cyc[2] - iss_cyc[1] - 1);
    end
    tests_run++;
    if (psum_log.size() == 4 && (psum_log[2] !== 16'd5 || psum_log[3] !== 16'd7)) begin
      tests_failed++;
      $display("FAIL stall_replay: got %0d,%0d want 5,7", psum_log[2], psum_log[3]);
    end
    drain(0, 100, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL stall_drain_timeout: no done"); end
    n = exp_q.size();
    tests_run++;
    if (got_q.size() != n) begin tests_failed++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL stall_out: got %0d want %0d", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit to;
    int n;
    int last;
    logic [15:0] e, g;
    for (int i = 0; i < 6; i++) begin
      add_k[i] = 16'(3 * i + 1);
      exp_q.push_back(16'(2 * (3 * i + 1)));
    end
    start_job(4'd2, 4'd6);
    feed(12, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL bp_feed_timeout: issued %0d want 12", psum_log.size()); end
    drain(1, 200, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL bp_drain_timeout: no done"); end
    for (int i = 0; i + 1 < vld_tr.size(); i++) begin
      if (vld_tr[i] && !rdy_tr[i]) begin
        tests_run++;
        if (vld_tr[i+1] !== 1'b1 || dat_tr[i+1] !== dat_tr[i]) begin
          tests_failed++;
          $display("FAIL bp_hold[%0d]: next valid=%b data=%0d want 1,%0d", i, vld_tr[i+1], dat_tr[i+1], dat_tr[i]);
        end
      end
    end
    n = exp_q.size();
    tests_run++;
    if (got_q.size() != n) begin tests_failed++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL bp_out: got %0d want %0d", g, e); end
    end
    exp_q.delete();
    last = vld_tr.size() - 1;
    n = 0;
    foreach (done_tr[i]) if (done_tr[i]) n++;
    tests_run++;
    if (n != 1 || !(vld_tr[last] && rdy_tr[last] && done_tr[last])) begin
      tests_failed++;
      $display("FAIL bp_done_on_last_accept: pulses=%0d last vld=%b rdy=%b done=%b want 1,1,1,1", n, vld_tr[last], rdy_tr[last], done_tr[last]);
    end
  endtask

  task automatic test_illegal_start();
    bit to;
    int n;
    logic [15:0] e, g;
    start_job(4'd1, 4'd0);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL illegal_nvec0: busy=%b want 0", busy); end
    start_job(4'd0, 4'd3);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL illegal_npass0: busy=%b want 0", busy); end
    start_job(4'd1, 4'd9);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL illegal_nvec_big: busy=%b want 0", busy); end
    for (int i = 0; i < DEPTH; i++) add_k[i] = 16'd1;
    start_job(4'd2, 4'd4);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'd2);
    feed(2, to);
    @(posedge clk); #1;
    num_pass = 4'd1; num_vec = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_start_busy: got %b want 1", busy); end
    feed(6, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL busy_start_feed: issued %0d want 8", psum_log.size()); end
    for (int i = 4; i < 8 && i < psum_log.size(); i++) begin
      tests_run++;
      if (psum_log[i] !== 16'd1) begin tests_failed++; $display("FAIL busy_start_psum[%0d]: got %0d want 1", i, psum_log[i]); end
    end
    drain(0, 100, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL busy_start_drain_timeout: no done"); end
    n = exp_q.size();
    tests_run++;
    if (got_q.size() != n) begin tests_failed++; $display("FAIL busy_start_count: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL busy_start_out: got %0d want %0d", g, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_pass();
    bit to;
    int n;
    logic [15:0] e, g;
    for (int i = 0; i < DEPTH; i++) add_k[i] = 16'd1;
    start_job(4'd3, 4'd4);
    feed(6, to);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, bus.issue_ready, bus.out_valid} !== 4'b0000 || bus.psum_to_row !== 16'h0 || bus.out_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: busy=%b done=%b ir=%b ov=%b psum=%h od=%h, want all 0", busy, done, bus.issue_ready, bus.out_valid, bus.psum_to_row, bus.out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add_k[i] = 16'(i + 1);
      exp_q.push_back(16'(i + 1));
    end
    start_job(4'd1, 4'd4);
    feed(4, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL midreset_feed_timeout: issued %0d want 4", psum_log.size()); end
    drain(0, 100, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL midreset_drain_timeout: no done"); end
    n = exp_q.size();
    tests_run++;
    if (got_q.size() != n) begin tests_failed++; $display("FAIL midreset_count: got %0d want %0d", got_q.size(), n); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      tests_run++;
      if (g !== e) begin tests_failed++; $display("FAIL midreset_out: got %0d want %0d", g, e); end
    end
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < ROW_LAT; i++) pipe[i] = 16'h0000;
    for (int i = 0; i < DEPTH; i++) add_k[i] = 16'h0000;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_stall();
    test_backpressure();
    test_illegal_start();
    test_reset_mid_pass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
